// File: rtl/commit_rename_table.sv
// commit_rename_table: architectural register file plus register-status table.
// Decode reads operands here and allocates destination tags; the ROB commits results here.
//
// Parameters:
//   TAG_WIDTH    ROB index width; tag 0 means "no producer"
//   XLEN         data width
// Ports:
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   rs1_addr -> rs1_data/busy/tag  source-1 lookup (combinational)
//   rs2_addr -> rs2_data/busy/tag  source-2 lookup (combinational)
//   alloc_en, alloc_rd, alloc_tag  destination rename from decode
//   commit_we, commit_addr,
//   commit_data, commit_tag        retirement write from the ROB
//   flush                          squash all speculative renames
//   busy_count                     registers currently busy (registered)
//   retire_count                   commits since reset, wraps at 2^32
// Configuration macro:
//   COMMIT_BYPASS_EN  forward a same-cycle commit onto the lookup ports
module commit_rename_table #(
    parameter int TAG_WIDTH = 8,
    parameter int XLEN      = 32
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [4:0]           rs1_addr,
    output logic [XLEN-1:0]      rs1_data,
    output logic                 rs1_busy,
    output logic [TAG_WIDTH-1:0] rs1_tag,

    input  logic [4:0]           rs2_addr,
    output logic [XLEN-1:0]      rs2_data,
    output logic                 rs2_busy,
    output logic [TAG_WIDTH-1:0] rs2_tag,

    input  logic                 alloc_en,
    input  logic [4:0]           alloc_rd,
    input  logic [TAG_WIDTH-1:0] alloc_tag,

    input  logic                 commit_we,
    input  logic [4:0]           commit_addr,
    input  logic [XLEN-1:0]      commit_data,
    input  logic [TAG_WIDTH-1:0] commit_tag,

    input  logic                 flush,

    output logic [5:0]           busy_count,
    output logic [31:0]          retire_count
);

    logic [XLEN-1:0]      regs     [32];
    logic [TAG_WIDTH-1:0] tags     [32];
    logic [31:0]          busy;

    logic [TAG_WIDTH-1:0] tags_nxt [32];
    logic [31:0]          busy_nxt;
    logic [5:0]           busy_pop;

    logic                 alloc_ok;
    logic                 commit_ok;
    logic                 commit_clr;

    assign alloc_ok   = alloc_en && (alloc_rd != 5'd0) && !flush;
    assign commit_ok  = commit_we && (commit_addr != 5'd0);
    // A commit only retires the rename if it comes from the newest producer.
    assign commit_clr = commit_ok && busy[commit_addr]
                        && (tags[commit_addr] == commit_tag);

    // Next rename state. Priority: flush, then alloc, then commit clear,
    // so a same-cycle alloc overrides a matching commit (WAW safety).
    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < 32; i++) begin
            tags_nxt[i] = tags[i];
        end
        if (flush) begin
            busy_nxt = '0;
            for (int i = 0; i < 32; i++) begin
                tags_nxt[i] = '0;
            end
        end else begin
            if (commit_clr) begin
                busy_nxt[commit_addr] = 1'b0;
                tags_nxt[commit_addr] = '0;
            end
            if (alloc_ok) begin
                busy_nxt[alloc_rd] = 1'b1;
                tags_nxt[alloc_rd] = alloc_tag;
            end
        end
        busy_nxt[0] = 1'b0;
        tags_nxt[0] = '0;
    end

    always_comb begin
        busy_pop = '0;
        for (int i = 0; i < 32; i++) begin
            busy_pop = busy_pop + {5'd0, busy_nxt[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy         <= '0;
            busy_count   <= '0;
            retire_count <= '0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
                tags[i] <= '0;
            end
        end else begin
            busy       <= busy_nxt;
            busy_count <= busy_pop;
            for (int i = 0; i < 32; i++) begin
                tags[i] <= tags_nxt[i];
            end
            if (commit_ok) begin
                regs[commit_addr] <= commit_data;
            end
            if (commit_we) begin
                retire_count <= retire_count + 32'd1;
            end
        end
    end

    // Lookup ports: identical logic for both sources.
    logic [4:0]           rd_addr [2];
    logic [XLEN-1:0]      rd_data [2];
    logic                 rd_busy [2];
    logic [TAG_WIDTH-1:0] rd_tag  [2];

    assign rd_addr[0] = rs1_addr;
    assign rd_addr[1] = rs2_addr;

    for (genvar p = 0; p < 2; p++) begin : g_rd
`ifdef COMMIT_BYPASS_EN
        logic hit;
        logic clr;
        // Forwarding is based on pre-edge state only.
        assign hit = commit_ok && (commit_addr == rd_addr[p]);
        assign clr = hit && commit_clr;
        assign rd_data[p] = hit ? commit_data : regs[rd_addr[p]];
        assign rd_busy[p] = busy[rd_addr[p]] && !clr;
`else
        assign rd_data[p] = regs[rd_addr[p]];
        assign rd_busy[p] = busy[rd_addr[p]];
`endif
        assign rd_tag[p] = rd_busy[p] ? tags[rd_addr[p]] : '0;
    end

    assign rs1_data = rd_data[0];
    assign rs1_busy = rd_busy[0];
    assign rs1_tag  = rd_tag[0];
    assign rs2_data = rd_data[1];
    assign rs2_busy = rd_busy[1];
    assign rs2_tag  = rd_tag[1];

endmodule

// File: tb/tb_commit_rename_table.sv
// tb_commit_rename_table: directed checks of lookup, rename, commit,
// flush and x0 handling for commit_rename_table.
module tb_commit_rename_table;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy;
    logic [7:0]  rs1_tag, rs2_tag;
    logic        alloc_en;
    logic [4:0]  alloc_rd;
    logic [7:0]  alloc_tag;
    logic        commit_we;
    logic [4:0]  commit_addr;
    logic [31:0] commit_data;
    logic [7:0]  commit_tag;
    logic        flush;
    logic [5:0]  busy_count;
    logic [31:0] retire_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    commit_rename_table dut (
        .clk          (clk),
        .rst          (rst),
        .rs1_addr     (rs1_addr),
        .rs1_data     (rs1_data),
        .rs1_busy     (rs1_busy),
        .rs1_tag      (rs1_tag),
        .rs2_addr     (rs2_addr),
        .rs2_data     (rs2_data),
        .rs2_busy     (rs2_busy),
        .rs2_tag      (rs2_tag),
        .alloc_en     (alloc_en),
        .alloc_rd     (alloc_rd),
        .alloc_tag    (alloc_tag),
        .commit_we    (commit_we),
        .commit_addr  (commit_addr),
        .commit_data  (commit_data),
        .commit_tag   (commit_tag),
        .flush        (flush),
        .busy_count   (busy_count),
        .retire_count (retire_count)
    );

    task automatic chk(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        alloc_en  = 1'b0;
        commit_we = 1'b0;
        flush     = 1'b0;
        #1;
    endtask

    task automatic do_alloc(input logic [4:0] rd, input logic [7:0] t);
        alloc_en  = 1'b1;
        alloc_rd  = rd;
        alloc_tag = t;
    endtask

    task automatic do_commit(input logic [4:0] a, input logic [7:0] t,
                             input logic [31:0] d);
        commit_we   = 1'b1;
        commit_addr = a;
        commit_tag  = t;
        commit_data = d;
    endtask

    initial begin
        rst = 1'b1;
        rs1_addr = '0; rs2_addr = '0;
        alloc_en = 1'b0; alloc_rd = '0; alloc_tag = '0;
        commit_we = 1'b0; commit_addr = '0; commit_data = '0;
        commit_tag = '0; flush = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        rs1_addr = 5'd5;
        #1;
        chk("rst_data", rs1_data, 32'h0);
        chk("rst_busy", {31'd0, rs1_busy}, 32'd0);
        chk("rst_tag", {24'd0, rs1_tag}, 32'd0);
        chk("rst_bcnt", {26'd0, busy_count}, 32'd0);
        chk("rst_rcnt", retire_count, 32'd0);

        // Alloc then matching commit
        do_alloc(5'd5, 8'd3);
        step();
        chk("t2_busy", {31'd0, rs1_busy}, 32'd1);
        chk("t2_tag", {24'd0, rs1_tag}, 32'd3);
        chk("t2_bcnt", {26'd0, busy_count}, 32'd1);
        do_commit(5'd5, 8'd3, 32'hDEADBEEF);
        step();
        chk("t2_data", rs1_data, 32'hDEADBEEF);
        chk("t2_busy0", {31'd0, rs1_busy}, 32'd0);
        chk("t2_tag0", {24'd0, rs1_tag}, 32'd0);
        chk("t2_rcnt", retire_count, 32'd1);
        chk("t2_bcnt0", {26'd0, busy_count}, 32'd0);

        // WAW rename, stale commit then current commit
        rs1_addr = 5'd7;
        do_alloc(5'd7, 8'd4);
        step();
        do_alloc(5'd7, 8'd9);
        step();
        chk("t3_tag9", {24'd0, rs1_tag}, 32'd9);
        do_commit(5'd7, 8'd4, 32'h11);
        step();
        chk("t3_stale_data", rs1_data, 32'h11);
        chk("t3_stale_busy", {31'd0, rs1_busy}, 32'd1);
        chk("t3_stale_tag", {24'd0, rs1_tag}, 32'd9);
        chk("t3_rcnt", retire_count, 32'd2);
        do_commit(5'd7, 8'd9, 32'h22);
        step();
        chk("t3_data", rs1_data, 32'h22);
        chk("t3_busy", {31'd0, rs1_busy}, 32'd0);
        chk("t3_bcnt", {26'd0, busy_count}, 32'd0);

        // Same-cycle alloc and commit: alloc wins, data still written
        rs2_addr = 5'd2;
        do_alloc(5'd2, 8'd5);
        step();
        do_alloc(5'd2, 8'd6);
        do_commit(5'd2, 8'd5, 32'hAA);
        step();
        chk("t4_data", rs2_data, 32'hAA);
        chk("t4_busy", {31'd0, rs2_busy}, 32'd1);
        chk("t4_tag", {24'd0, rs2_tag}, 32'd6);
        chk("t4_rcnt", retire_count, 32'd4);

        // Flush with alloc dropped
        do_alloc(5'd1, 8'd1);
        step();
        do_alloc(5'd3, 8'd7);
        step();
        chk("t5_bcnt3", {26'd0, busy_count}, 32'd3);
        flush = 1'b1;
        do_alloc(5'd4, 8'd8);
        step();
        rs1_addr = 5'd4;
        #1;
        chk("t5_bcnt0", {26'd0, busy_count}, 32'd0);
        chk("t5_x4_busy", {31'd0, rs1_busy}, 32'd0);
        chk("t5_x4_tag", {24'd0, rs1_tag}, 32'd0);
        chk("t5_x2_data", rs2_data, 32'hAA);
        chk("t5_x2_busy", {31'd0, rs2_busy}, 32'd0);
        rs1_addr = 5'd7;
        #1;
        chk("t5_x7_data", rs1_data, 32'h22);

        // x0 ignores alloc and commit but the commit still counts
        rs1_addr = 5'd0;
        do_alloc(5'd0, 8'd2);
        do_commit(5'd0, 8'd2, 32'h5);
        step();
        chk("t5_x0_data", rs1_data, 32'h0);
        chk("t5_x0_busy", {31'd0, rs1_busy}, 32'd0);
        chk("t5_x0_tag", {24'd0, rs1_tag}, 32'd0);
        chk("t5_x0_bcnt", {26'd0, busy_count}, 32'd0);
        chk("t5_x0_rcnt", retire_count, 32'd5);

        // Commit during flush writes data and counts
        rs1_addr = 5'd1;
        do_alloc(5'd1, 8'd1);
        step();
        flush = 1'b1;
        do_commit(5'd1, 8'd1, 32'h77);
        step();
        chk("t5f_data", rs1_data, 32'h77);
        chk("t5f_busy", {31'd0, rs1_busy}, 32'd0);
        chk("t5f_rcnt", retire_count, 32'd6);

        // Same-cycle visibility of a commit
        rs1_addr = 5'd5;
        do_alloc(5'd5, 8'd3);
        step();
        chk("t6_bcnt", {26'd0, busy_count}, 32'd1);
        do_commit(5'd5, 8'd3, 32'h55);
        #1;
`ifdef COMMIT_BYPASS_EN
        chk("t6_byp_data", rs1_data, 32'h55);
        chk("t6_byp_busy", {31'd0, rs1_busy}, 32'd0);
        chk("t6_byp_tag", {24'd0, rs1_tag}, 32'd0);
`else
        chk("t6_old_data", rs1_data, 32'hDEADBEEF);
        chk("t6_old_busy", {31'd0, rs1_busy}, 32'd1);
        chk("t6_old_tag", {24'd0, rs1_tag}, 32'd3);
`endif
        step();
        chk("t6_data", rs1_data, 32'h55);
        chk("t6_busy", {31'd0, rs1_busy}, 32'd0);
        chk("t6_rcnt", retire_count, 32'd7);
        chk("t6_bcnt0", {26'd0, busy_count}, 32'd0);

        // Reset overrides simultaneous alloc and commit
        rst = 1'b1;
        do_alloc(5'd5, 8'd9);
        do_commit(5'd5, 8'd9, 32'h99);
        step();
        rst = 1'b0;
        #1;
        chk("rst2_data", rs1_data, 32'h0);
        chk("rst2_busy", {31'd0, rs1_busy}, 32'd0);
        chk("rst2_rcnt", retire_count, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
